keypad_scanner: RTL and testbench

- Scans a 4x4 active-low matrix keypad and debounces it, turning physical key presses into single, acknowledged key events (code 0-15).
- It is the input-side counterpart of the multiplexed seven-segment display path: the display drives digits out one at a time, and this block drives keypad rows out one at a time and reads the columns back.
- It feeds cell selections to the game controller through a one-entry valid/ack buffer.

---
 rtl/keypad_if.sv | 25 ++
 rtl/keypad_scanner.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Key event handshake between the keypad scanner (master) and its consumer (slave).
// The master holds key_code and key_valid until the consumer acks; key_held and overrun are status outputs.
interface keypad_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overrun,
    output key_ack
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce: one event per press, ready 4*SCAN_TICKS*DEBOUNCE_SCANS cycles after it settles.
// One-entry valid/ack buffer; a press accepted while an event is still pending is dropped and flagged on overrun.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 41666,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [3:0] row,
  input  logic [3:0] col,
  keypad_if.master   key
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PRESS_CHK   = 2'd1;
  localparam logic [1:0] PRESSED     = 2'd2;
  localparam logic [1:0] RELEASE_CHK = 2'd3;

  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [TW-1:0] tick_cnt;
  logic [1:0]    row_idx;

  // Scan accumulator over rows 0..2: number of lows seen (saturating at 2) and the first key found.
  logic [1:0]    acc_lows;
  logic [3:0]    acc_key;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] db_cnt_nxt;
  logic [CW-1:0] db_cnt_inc;
  logic [3:0]    candidate;
  logic [3:0]    candidate_nxt;
  logic          accept;

  logic          row_tick;
  logic          scan_eval;
  logic [2:0]    row_lows;
  logic [1:0]    row_col;
  logic [1:0]    row_lows_sat;
  logic [2:0]    tot_sum;
  logic [1:0]    tot_lows;
  logic [3:0]    hit_key;
  logic          scan_none;
  logic          scan_single;

  assign row = ~(4'b0001 << row_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  assign row_tick  = (tick_cnt == TICK_LAST);
  assign scan_eval = row_tick && (row_idx == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      row_idx  <= 2'd0;
    end else if (row_tick) begin
      tick_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Lowest-numbered low column wins the index; the count alone decides single vs multi.
  always_comb begin
    row_lows = 3'd0;
    row_col  = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_sync[c]) begin
        row_lows = row_lows + 3'd1;
        row_col  = 2'(c);
      end
    end
  end

  assign row_lows_sat = (row_lows >= 3'd2) ? 2'd2 : row_lows[1:0];
  assign tot_sum      = {1'b0, acc_lows} + {1'b0, row_lows_sat};
  assign tot_lows     = (tot_sum >= 3'd2) ? 2'd2 : tot_sum[1:0];
  assign hit_key      = (acc_lows == 2'd0) ? {row_idx, row_col} : acc_key;
  assign scan_none    = (tot_lows == 2'd0);
  assign scan_single  = (tot_lows == 2'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_lows <= 2'd0;
      acc_key  <= 4'd0;
    end else if (row_tick) begin
      if (row_idx == 2'd3) begin
        acc_lows <= 2'd0;
        acc_key  <= 4'd0;
      end else begin
        acc_lows <= tot_lows;
        acc_key  <= hit_key;
      end
    end
  end

  assign db_cnt_inc = db_cnt + CW'(1);

  always_comb begin
    state_nxt     = state;
    db_cnt_nxt    = db_cnt;
    candidate_nxt = candidate;
    accept        = 1'b0;
    if (scan_eval) begin
      case (state)
        IDLE: begin
          if (scan_single) begin
            candidate_nxt = hit_key;
            if (DEBOUNCE_SCANS == 1) begin
              accept     = 1'b1;
              state_nxt  = PRESSED;
              db_cnt_nxt = '0;
            end else begin
              state_nxt  = PRESS_CHK;
              db_cnt_nxt = CW'(1);
            end
          end
        end
        PRESS_CHK: begin
          if (scan_single && (hit_key == candidate)) begin
            if (db_cnt_inc == CNT_DONE) begin
              accept     = 1'b1;
              state_nxt  = PRESSED;
              db_cnt_nxt = '0;
            end else begin
              db_cnt_nxt = db_cnt_inc;
            end
          end else if (scan_single) begin
            candidate_nxt = hit_key;
            db_cnt_nxt    = CW'(1);
          end else begin
            state_nxt  = IDLE;
            db_cnt_nxt = '0;
          end
        end
        PRESSED: begin
          if (scan_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt  = IDLE;
              db_cnt_nxt = '0;
            end else begin
              state_nxt  = RELEASE_CHK;
              db_cnt_nxt = CW'(1);
            end
          end
        end
        default: begin
          // Multi-key scans count as still held, so they bounce back to PRESSED.
          if (scan_none) begin
            if (db_cnt_inc == CNT_DONE) begin
              state_nxt  = IDLE;
              db_cnt_nxt = '0;
            end else begin
              db_cnt_nxt = db_cnt_inc;
            end
          end else begin
            state_nxt  = PRESSED;
            db_cnt_nxt = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      db_cnt    <= '0;
      candidate <= 4'd0;
    end else begin
      state     <= state_nxt;
      db_cnt    <= db_cnt_nxt;
      candidate <= candidate_nxt;
    end
  end

  assign key.key_held = (state == PRESSED) || (state == RELEASE_CHK);

  // An ack landing on the accept cycle frees the slot, so the new event loads without overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key.key_code  <= 4'd0;
      key.key_valid <= 1'b0;
      key.overrun   <= 1'b0;
    end else begin
      key.overrun <= 1'b0;
      if (accept) begin
        if (key.key_valid && !key.key_ack) begin
          key.overrun <= 1'b1;
        end else begin
          key.key_code  <= candidate_nxt;
          key.key_valid <= 1'b1;
        end
      end else if (key.key_ack && key.key_valid) begin
        key.key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives col from row and a pressed-key mask,
// expected events are queued by the stimulus and popped by a negedge monitor.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] pressed = 16'h0000;

  int          n_vec = 0;
  int          n_err = 0;
  int          overrun_seen = 0;
  logic [3:0]  exp_q[$];
  logic        prev_valid = 1'b0;
  logic        prev_ack = 1'b0;

  keypad_if kif();

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .row     (row),
    .col     (col),
    .key     (kif)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a new event is valid rising, or valid held across a cycle in which the old one was acked.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (kif.key_valid && (!prev_valid || prev_ack)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got key %0d, expected no event", kif.key_code);
        end else begin
          check("event_code", 8'(kif.key_code), 8'(exp_q.pop_front()));
          check("event_held", 8'(kif.key_held), 8'd1);
        end
      end
      if (kif.overrun) begin
        overrun_seen++;
        check("overrun_code_kept", 8'(kif.key_code), 8'd3);
      end
      prev_valid = kif.key_valid;
      prev_ack   = kif.key_ack;
    end
  end

  // Returns #1 after each of n scan-evaluation edges (row 0111 -> 1110).
  task automatic scans(input int n);
    bit         done;
    logic [3:0] last;
    for (int i = 0; i < n; i++) begin
      done = 1'b0;
      last = row;
      for (int g = 0; g < 40 && !done; g++) begin
        @(posedge clk);
        #1;
        if (last == 4'b0111 && row == 4'b1110) done = 1'b1;
        last = row;
      end
      if (!done) begin
        n_vec++;
        n_err++;
        $display("FAIL scan_timeout: got no row wrap in 40 cycles, expected one per 16");
      end
    end
  endtask

  task automatic ack_pulse();
    kif.key_ack = 1'b1;
    @(posedge clk);
    #1;
    kif.key_ack = 1'b0;
  endtask

  initial begin
    kif.key_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", 8'(row), 8'b1110);
    check("rst_code", 8'(kif.key_code), 8'd0);
    check("rst_valid", 8'(kif.key_valid), 8'd0);
    check("rst_held", 8'(kif.key_held), 8'd0);
    check("rst_overrun", 8'(kif.overrun), 8'd0);
    reset_n = 1'b1;
    scans(1);

    // Key 9 held: one event, no repeat, ack clears, release needs 3 scans.
    pressed = 16'h0200;
    exp_q.push_back(4'd9);
    scans(3);
    check("k9_valid", 8'(kif.key_valid), 8'd1);
    check("k9_held", 8'(kif.key_held), 8'd1);
    scans(2);
    ack_pulse();
    check("k9_acked", 8'(kif.key_valid), 8'd0);
    ack_pulse();
    scans(1);
    pressed = 16'h0000;
    scans(2);
    check("k9_still_held", 8'(kif.key_held), 8'd1);
    scans(1);
    check("k9_released", 8'(kif.key_held), 8'd0);

    // Key 5 bounce: 2 on, 1 off, 2 on, 1 off, then 3 on.
    pressed = 16'h0020; scans(2);
    pressed = 16'h0000; scans(1);
    pressed = 16'h0020; scans(2);
    pressed = 16'h0000; scans(1);
    check("k5_bounce_valid", 8'(kif.key_valid), 8'd0);
    pressed = 16'h0020;
    exp_q.push_back(4'd5);
    scans(3);
    check("k5_valid", 8'(kif.key_valid), 8'd1);
    ack_pulse();
    scans(1);
    pressed = 16'h0000; scans(3);

    // Keys 0 and 15 together are ignored; key 0 alone is accepted.
    pressed = 16'h8001; scans(3);
    check("multi_valid", 8'(kif.key_valid), 8'd0);
    check("multi_held", 8'(kif.key_held), 8'd0);
    pressed = 16'h0001;
    exp_q.push_back(4'd0);
    scans(3);
    check("k0_valid", 8'(kif.key_valid), 8'd1);
    ack_pulse();
    scans(1);
    pressed = 16'h0000; scans(3);

    // Key 3 left unacked; key 7 overruns; key 7 again lands on an ack.
    pressed = 16'h0008;
    exp_q.push_back(4'd3);
    scans(3);
    pressed = 16'h0000; scans(3);
    pressed = 16'h0080; scans(3);
    check("ovr_pulse", 8'(kif.overrun), 8'd1);
    check("ovr_code", 8'(kif.key_code), 8'd3);
    pressed = 16'h0000; scans(3);
    pressed = 16'h0080;
    exp_q.push_back(4'd7);
    scans(2);
    for (int g = 0; g < 20 && row != 4'b0111; g++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    kif.key_ack = 1'b1;
    @(posedge clk);
    #1;
    kif.key_ack = 1'b0;
    check("coinc_code", 8'(kif.key_code), 8'd7);
    check("coinc_valid", 8'(kif.key_valid), 8'd1);
    check("coinc_overrun", 8'(kif.overrun), 8'd0);
    ack_pulse();
    scans(1);
    pressed = 16'h0000; scans(3);

    // Reset in the middle of PRESS_CHK for key 10.
    pressed = 16'h0400; scans(2);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    pressed = 16'h0000;
    @(negedge clk);
    check("mid_rst_row", 8'(row), 8'b1110);
    check("mid_rst_valid", 8'(kif.key_valid), 8'd0);
    check("mid_rst_held", 8'(kif.key_held), 8'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    scans(1);
    pressed = 16'h0400; scans(2);
    check("post_rst_valid", 8'(kif.key_valid), 8'd0);
    exp_q.push_back(4'd10);
    scans(1);
    check("k10_valid", 8'(kif.key_valid), 8'd1);
    check("k10_held", 8'(kif.key_held), 8'd1);

    repeat (2) @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    check("overrun_count", 8'(overrun_seen), 8'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
